// File: rtl/vend_pkg.sv
// Shared types and default timing for the vending FSM and its dispense stage.
package vend_pkg;

  localparam int CHG_W         = 3;
  localparam int MOTOR_CYCLES  = 4;
  localparam int PULSE_CYCLES  = 2;
  localparam int GAP_CYCLES    = 2;
  localparam int SENSE_TIMEOUT = 8;
  localparam int TMR_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    MOTOR,
    EJECT,
    WAIT_SENSE,
    GAP,
    DONE,
    FAULT
  } vend_state_e;

endpackage

// File: rtl/vend_phase_timer.sv
// Loadable down-counter with a zero flag; one instance times every dispense phase.
module vend_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: motor run, then coin-by-coin eject with sensor confirmation.
// Optional VEND_DISPENSE_RETRY_EN: one extra eject pulse per coin before faulting.
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES  = vend_pkg::MOTOR_CYCLES,
  parameter int PULSE_CYCLES  = vend_pkg::PULSE_CYCLES,
  parameter int GAP_CYCLES    = vend_pkg::GAP_CYCLES,
  parameter int SENSE_TIMEOUT = vend_pkg::SENSE_TIMEOUT,
  parameter int CHG_W         = vend_pkg::CHG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vend,
  input  logic [CHG_W-1:0] change,
  input  logic             coin_sense,
  input  logic             fault_clr,
  output logic             motor_on,
  output logic             coin_eject,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CHG_W-1:0] coins_left
);

  import vend_pkg::*;

  vend_state_e      state, state_nxt;
  logic [CHG_W-1:0] coins_nxt;
  logic             tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
`ifdef VEND_DISPENSE_RETRY_EN
  logic             retry, retry_nxt;
`endif

  always_comb begin
    state_nxt = state;
    coins_nxt = coins_left;
`ifdef VEND_DISPENSE_RETRY_EN
    retry_nxt = retry;
`endif
    case (state)
      IDLE: begin
`ifdef VEND_DISPENSE_RETRY_EN
        retry_nxt = 1'b0;
`endif
        if (vend) begin
          state_nxt = MOTOR;
          coins_nxt = change;
        end
      end
      MOTOR:      if (tmr_zero) state_nxt = (coins_left == '0) ? DONE : EJECT;
      EJECT:      if (tmr_zero) state_nxt = WAIT_SENSE;
      WAIT_SENSE: begin
        if (coin_sense) begin
          coins_nxt = (coins_left == '0) ? '0 : coins_left - 1'b1;
          state_nxt = (coins_left <= CHG_W'(1)) ? DONE : GAP;
`ifdef VEND_DISPENSE_RETRY_EN
          retry_nxt = 1'b0;
`endif
        end else if (tmr_zero) begin
`ifdef VEND_DISPENSE_RETRY_EN
          // First miss on this coin gets one more pulse; the second one faults.
          if (!retry) begin
            retry_nxt = 1'b1;
            state_nxt = EJECT;
          end else begin
            state_nxt = FAULT;
          end
`else
          state_nxt = FAULT;
`endif
        end
      end
      GAP:  if (tmr_zero) state_nxt = EJECT;
      DONE: state_nxt = IDLE;
      FAULT: begin
        if (fault_clr) begin
          state_nxt = IDLE;
          coins_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every state change reloads the timer with the length of the phase being entered.
  always_comb begin
    tmr_load = (state_nxt != state);
    case (state_nxt)
      MOTOR:      tmr_val = TMR_W'(MOTOR_CYCLES - 1);
      EJECT:      tmr_val = TMR_W'(PULSE_CYCLES - 1);
      WAIT_SENSE: tmr_val = TMR_W'(SENSE_TIMEOUT - 1);
      GAP:        tmr_val = TMR_W'(GAP_CYCLES - 1);
      default:    tmr_val = '0;
    endcase
  end

  vend_phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      coins_left <= '0;
      motor_on   <= 1'b0;
      coin_eject <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
`ifdef VEND_DISPENSE_RETRY_EN
      retry      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      coins_left <= coins_nxt;
      motor_on   <= (state_nxt == MOTOR);
      coin_eject <= (state_nxt == EJECT);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
      fault      <= (state_nxt == FAULT);
`ifdef VEND_DISPENSE_RETRY_EN
      retry      <= retry_nxt;
`endif
    end
  end

endmodule
